time_seg_display: RTL and testbench

Display-side consumer of the packed time word produced by the team's free-running clock counters. It converts the selected pair of time fields to BCD with a sequential double-dabble engine and drives a 4-digit, common-anode, multiplexed 7-segment display. Digit registers update atomically, so the panel never shows a half-converted value.

---
 rtl/time_seg_display.sv | 149 ++++++++++++++
 tb/tb_time_seg_display.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_seg_display.sv
// Converts two selected time fields to BCD with a sequential double-dabble engine
// and scans them onto a 4-digit common-anode 7-segment display.
module time_seg_display #(
   parameter int SCAN_DIV = 1,
   parameter int HR12     = 1
) (
   input  logic        kh_clk,
   input  logic        reset,
   input  logic [26:0] time_in,
   input  logic        mode,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        upd
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [9:0] SCAN_LAST = 10'(SCAN_DIV - 1);
   localparam logic [3:0] BLANK     = 4'hF;

   state_t state, state_nxt;

   logic [2:0]       sh_cnt;
   logic [13:0]      up_sr, lo_sr;     // {tens, units, binary[5:0]}
   logic             snap_mode, snap_dp;
   logic [3:0][3:0]  dig;
   logic             dp_on;
   logic [5:0]       up_fld, lo_fld;
   logic [9:0]       scan_cnt;
   logic [1:0]       dig_idx;
   logic             out_en;

   function automatic logic [13:0] dd_step(input logic [13:0] sr);
      logic [13:0] t;
      t = sr;
      if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
      if (t[9:6]   >= 4'd5) t[9:6]   = t[9:6]   + 4'd3;
      return {t[12:0], 1'b0};
   endfunction

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (sh_cnt == 3'd5) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Hour 0 shows as 12 only in the 12-hour build; the hour never exceeds 31.
   always_comb begin
      up_fld = time_in[21:16];
      lo_fld = time_in[15:10];
      if (!mode) begin
         up_fld = {1'b0, time_in[26:22]};
         if (HR12 != 0 && time_in[26:22] == 5'd0) up_fld = 6'd12;
         lo_fld = time_in[21:16];
      end
   end

   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
         sh_cnt    <= '0;
         up_sr     <= '0;
         lo_sr     <= '0;
         snap_mode <= 1'b0;
         snap_dp   <= 1'b0;
         dig       <= {4{BLANK}};
         dp_on     <= 1'b0;
         upd       <= 1'b0;
      end else begin
         upd <= (state == DONE);
         case (state)
            LOAD: begin
               up_sr     <= {8'd0, up_fld};
               lo_sr     <= {8'd0, lo_fld};
               snap_mode <= mode;
               snap_dp   <= mode ? (time_in[9:0] < 10'd500) : 1'b1;
               sh_cnt    <= '0;
            end
            SHIFT: begin
               up_sr  <= dd_step(up_sr);
               lo_sr  <= dd_step(lo_sr);
               sh_cnt <= sh_cnt + 3'd1;
            end
            DONE: begin
               dig[3] <= (!snap_mode && up_sr[13:10] == 4'd0) ? BLANK : up_sr[13:10];
               dig[2] <= up_sr[9:6];
               dig[1] <= lo_sr[13:10];
               dig[0] <= lo_sr[9:6];
               dp_on  <= snap_dp;
            end
            default: ;
         endcase
      end
   end

   // out_en holds the panel dark for the first edge after reset.
   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         dig_idx  <= '0;
         out_en   <= 1'b0;
         an       <= 4'hF;
         seg      <= 7'h7F;
         dp       <= 1'b1;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 10'd1;
         end
         out_en <= 1'b1;
         if (out_en) begin
            an  <= ~(4'b0001 << dig_idx);
            seg <= seg_enc(dig[dig_idx]);
            dp  <= ~(dig_idx == 2'd2 && dp_on);
         end
      end
   end

endmodule

// File: tb/tb_time_seg_display.sv
// Bench for time_seg_display: cycle-count reference model checked every cycle on
// two instances (scan divider 1 and 2), plus hand-computed display readings.
module tb_time_seg_display;

   logic        kh_clk = 1'b0;
   logic        reset  = 1'b1;
   logic [26:0] time_in;
   logic        mode;
   logic [3:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b, upd_a, upd_b;

   int total = 0;
   int bad   = 0;

   time_seg_display #(.SCAN_DIV(1), .HR12(1)) dut_a (
      .kh_clk(kh_clk), .reset(reset), .time_in(time_in), .mode(mode),
      .an(an_a), .seg(seg_a), .dp(dp_a), .upd(upd_a));

   time_seg_display #(.SCAN_DIV(2), .HR12(1)) dut_b (
      .kh_clk(kh_clk), .reset(reset), .time_in(time_in), .mode(mode),
      .an(an_b), .seg(seg_b), .dp(dp_b), .upd(upd_b));

   always #5 kh_clk = ~kh_clk;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                          SB = 7'b1111111;

   function automatic logic [26:0] pack(int hr, int mi, int sc, int ms);
      return {5'(hr), 6'(mi), 6'(sc), 10'(ms)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [11];
   int         k;
   int         m_dig [4];
   bit         m_dp;
   int         s_up, s_lo;
   bit         s_mode, s_dp;
   logic [3:0] e_an  [2];
   logic [6:0] e_seg [2];
   logic       e_dp  [2];
   logic       e_upd;

   initial begin
      seg_tab = '{S0, S1, S2, S3, S4, S5, S6, S7, 7'b0000000, S9, SB};
      k = 0; m_dig = '{10, 10, 10, 10}; m_dp = 0; e_upd = 0;
      s_up = 0; s_lo = 0; s_mode = 0; s_dp = 0;
      for (int i = 0; i < 2; i++) begin e_an[i] = 4'hF; e_seg[i] = SB; e_dp[i] = 1; end
      forever begin
         @(posedge kh_clk or posedge reset);
         if (reset) begin
            k = 0; m_dig = '{10, 10, 10, 10}; m_dp = 0; e_upd = 0;
            for (int i = 0; i < 2; i++) begin e_an[i] = 4'hF; e_seg[i] = SB; e_dp[i] = 1; end
         end else begin
            k++;
            if (k >= 2) begin
               for (int i = 0; i < 2; i++) begin
                  int idx;
                  idx      = ((k - 1) / (i + 1)) % 4;
                  e_an[i]  = ~(4'b0001 << idx);
                  e_seg[i] = seg_tab[m_dig[idx]];
                  e_dp[i]  = !(idx == 2 && m_dp);
               end
            end
            e_upd = (k % 9 == 0);
            if (k % 9 == 2) begin
               s_mode = mode;
               if (mode) begin
                  s_up = time_in[21:16]; s_lo = time_in[15:10];
                  s_dp = (time_in[9:0] < 500);
               end else begin
                  s_up = time_in[26:22]; s_lo = time_in[21:16]; s_dp = 1;
                  if (s_up == 0) s_up = 12;
               end
            end
            if (k % 9 == 0) begin
               m_dig[3] = (!s_mode && s_up / 10 == 0) ? 10 : s_up / 10;
               m_dig[2] = s_up % 10;
               m_dig[1] = s_lo / 10;
               m_dig[0] = s_lo % 10;
               m_dp     = s_dp;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge kh_clk);
      chk("an_a",  an_a,  e_an[0]);
      chk("seg_a", seg_a, e_seg[0]);
      chk("dp_a",  dp_a,  e_dp[0]);
      chk("upd_a", upd_a, e_upd);
      chk("an_b",  an_b,  e_an[1]);
      chk("seg_b", seg_b, e_seg[1]);
      chk("dp_b",  dp_b,  e_dp[1]);
      chk("upd_b", upd_b, e_upd);
   end

   // ---------------- directed helpers ----------------
   task automatic check_lit(input string name, input logic [3:0] an_val,
                            input logic [6:0] seg_exp, input logic dp_exp);
      bit found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge kh_clk);
         if (an_a == an_val) found = 1;
      end
      chk({name, "_found"}, found, 1);
      chk({name, "_seg"}, seg_a, seg_exp);
      chk({name, "_dp"}, dp_a, dp_exp);
   endtask

   task automatic wait_upd();
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge kh_clk);
         if (upd_a) seen = 1;
      end
      chk("upd_seen", seen, 1);
   endtask

   task automatic release_check();
      logic [3:0] seq [8];
      int first = 0;
      seq = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
      @(negedge kh_clk);
      reset = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge kh_clk);
         if (upd_a && first == 0) first = n;
         if (n == 1) chk("an_a_first_edge", an_a, 4'b1111);
         if (n == 2) chk("an_a_second_edge", an_a, 4'b1101);
         if (n == 2) chk("an_b_second_edge", an_b, 4'b1110);
         if (n >= 3 && n <= 10) chk("an_b_scan_seq", an_b, seq[n-3]);
      end
      chk("upd_latency", first, 9);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge kh_clk);
   endtask

   initial begin
      time_in = pack(0, 5, 0, 0);
      mode    = 1'b0;
      idle_cycles(3);
      chk("rst_an", an_a, 4'hF);
      chk("rst_seg", seg_a, SB);
      chk("rst_dp", dp_a, 1'b1);
      chk("rst_upd", upd_a, 1'b0);
      release_check();

      // midnight in 12-hour mode reads 12.05
      check_lit("mid_d3", 4'b0111, S1, 1'b1);
      check_lit("mid_d2", 4'b1011, S2, 1'b0);
      check_lit("mid_d1", 4'b1101, S0, 1'b1);
      check_lit("mid_d0", 4'b1110, S5, 1'b1);

      // 9:59 blanks the hour tens
      time_in = pack(9, 59, 0, 0);
      idle_cycles(20);
      check_lit("blk_d3", 4'b0111, SB, 1'b1);
      check_lit("blk_d2", 4'b1011, S9, 1'b0);
      check_lit("blk_d1", 4'b1101, S5, 1'b1);
      check_lit("blk_d0", 4'b1110, S9, 1'b1);

      // MM.SS with dp blink
      mode    = 1'b1;
      time_in = pack(3, 59, 7, 600);
      idle_cycles(20);
      check_lit("ms_d3", 4'b0111, S5, 1'b1);
      check_lit("ms_d2", 4'b1011, S9, 1'b1);
      check_lit("ms_d1", 4'b1101, S0, 1'b1);
      check_lit("ms_d0", 4'b1110, S7, 1'b1);
      time_in = pack(3, 59, 7, 100);
      idle_cycles(20);
      check_lit("blink_d2", 4'b1011, S9, 1'b0);

      // change inputs in the third SHIFT cycle
      wait_upd();
      idle_cycles(4);
      mode    = 1'b0;
      time_in = pack(12, 34, 0, 0);
      wait_upd();
      check_lit("old_d0", 4'b1110, S7, 1'b1);
      wait_upd();
      check_lit("new_d0", 4'b1110, S4, 1'b1);
      check_lit("new_d3", 4'b0111, S1, 1'b1);

      // reset mid-SHIFT
      wait_upd();
      idle_cycles(4);
      reset = 1'b1;
      #1;
      chk("mid_rst_an_a", an_a, 4'hF);
      chk("mid_rst_seg_a", seg_a, SB);
      chk("mid_rst_dp_a", dp_a, 1'b1);
      chk("mid_rst_an_b", an_b, 4'hF);
      chk("mid_rst_upd_b", upd_b, 1'b0);
      mode    = 1'b1;
      time_in = pack(0, 63, 0, 0);
      idle_cycles(2);
      release_check();

      // out-of-range minute converts arithmetically
      check_lit("m63_d3", 4'b0111, S6, 1'b1);
      check_lit("m63_d2", 4'b1011, S3, 1'b0);
      idle_cycles(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
